// File: rtl/formula_sum_isqrt_n_fsm.sv
// Sums isqrt(arg[i]) over N_ARGS operands by issuing them to N_ISQRT external
// isqrt lanes in rounds and accumulating lane results as they return.
module formula_sum_isqrt_n_fsm #(
  parameter int N_ARGS  = 3,
  parameter int N_ISQRT = 2,
  parameter int W       = 32,
  parameter int RES_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arg_vld,
  output logic                     arg_rdy,
  input  logic [N_ARGS*W-1:0]      args,
  output logic                     res_vld,
  output logic [RES_W-1:0]         res,
  output logic [N_ISQRT-1:0]       isqrt_x_vld,
  output logic [N_ISQRT*W-1:0]     isqrt_x,
  input  logic [N_ISQRT-1:0]       isqrt_y_vld,
  input  logic [N_ISQRT*(W/2)-1:0] isqrt_y
);

  localparam int HW = W / 2;
  localparam int BW = $clog2(N_ARGS + 2 * N_ISQRT + 1);
  localparam int EW = (RES_W > HW) ? RES_W : HW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [N_ARGS*W-1:0]  args_q;
  logic [BW-1:0]        base_q;
  logic [N_ISQRT-1:0]   launched_q;
  logic [N_ISQRT-1:0]   done_q;
  logic [RES_W-1:0]     acc_q;
  logic [RES_W-1:0]     res_q;
  logic                 res_vld_q;
  logic [N_ISQRT-1:0]   x_vld_q;
  logic [N_ISQRT*W-1:0] x_q;

  logic [BW-1:0]        next_base_d;
  logic [BW-1:0]        issue_base_d;
  logic [N_ARGS*W-1:0]  issue_args_d;
  logic [N_ISQRT-1:0]   issue_mask_d;
  logic [N_ISQRT*W-1:0] issue_x_d;
  logic [N_ISQRT-1:0]   y_hit_d;
  logic                 all_done_d;
  logic                 last_round_d;
  logic [EW-1:0]        acc_sum_d;
  logic [RES_W-1:0]     acc_d;

  assign arg_rdy     = (state_q == S_IDLE);
  assign res_vld     = res_vld_q;
  assign res         = res_q;
  assign isqrt_x_vld = x_vld_q;
  assign isqrt_x     = x_q;

  // The next round's operands are prepared while leaving IDLE or WAIT, so the
  // launch strobes are already registered during the ISSUE cycle.
  assign next_base_d  = base_q + BW'(N_ISQRT);
  assign last_round_d = (next_base_d >= BW'(N_ARGS));
  assign issue_base_d = (state_q == S_IDLE) ? '0 : next_base_d;
  assign issue_args_d = (state_q == S_IDLE) ? args : args_q;

  for (genvar gi = 0; gi < N_ISQRT; gi++) begin : g_lane
    logic [BW-1:0] idx;
    logic [W-1:0]  lane_x;

    assign idx              = issue_base_d + BW'(gi);
    assign issue_mask_d[gi] = (idx < BW'(N_ARGS));

    always_comb begin
      lane_x = '0;
      for (int k = 0; k < N_ARGS; k++) begin
        if (idx == BW'(k)) lane_x = issue_args_d[k*W +: W];
      end
    end

    assign issue_x_d[gi*W +: W] = lane_x;
  end

  // Only the first strobe of a launched lane counts toward the sum.
  assign y_hit_d    = isqrt_y_vld & launched_q & ~done_q;
  assign all_done_d = (((done_q | y_hit_d) & launched_q) == launched_q);

  always_comb begin
    acc_sum_d = EW'(acc_q);
    for (int j = 0; j < N_ISQRT; j++) begin
      if (y_hit_d[j]) acc_sum_d = acc_sum_d + EW'(isqrt_y[j*HW +: HW]);
    end
  end

  assign acc_d = acc_sum_d[RES_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      args_q     <= '0;
      base_q     <= '0;
      launched_q <= '0;
      done_q     <= '0;
      acc_q      <= '0;
      res_q      <= '0;
      res_vld_q  <= 1'b0;
      x_vld_q    <= '0;
      x_q        <= '0;
    end else begin
      res_vld_q <= 1'b0;
      x_vld_q   <= '0;
      case (state_q)
        S_IDLE: begin
          if (arg_vld) begin
            args_q     <= args;
            acc_q      <= '0;
            base_q     <= '0;
            launched_q <= issue_mask_d;
            done_q     <= '0;
            x_vld_q    <= issue_mask_d;
            x_q        <= issue_x_d;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          acc_q  <= acc_d;
          done_q <= done_q | y_hit_d;
          if (all_done_d) begin
            if (last_round_d) begin
              res_q     <= acc_d;
              res_vld_q <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              base_q     <= next_base_d;
              launched_q <= issue_mask_d;
              done_q     <= '0;
              x_vld_q    <= issue_mask_d;
              x_q        <= issue_x_d;
              state_q    <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_formula_sum_isqrt_n_fsm.sv
// Scoreboard bench: three configurations, each with behavioural isqrt lanes,
// an expected-launch queue and an expected-result queue popped by a monitor.
module tb_formula_sum_isqrt_n_fsm;

  localparam int W    = 32;
  localparam int HW   = 16;
  localparam int NCFG = 3;

  typedef struct {
    longint res;
    int     t_acc;
    int     lat;
  } exp_t;

  typedef struct {
    int     lane;
    longint val;
  } launch_t;

  typedef struct {
    int            lane;
    int            due;
    logic [HW-1:0] val;
  } pend_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_fin = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int cfg, input string nm, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL cfg%0d %s: got %0d, expected %0d (cycle %0d)", cfg, nm, got, want, cyc);
    end
  endtask

  // Floor square root by bisection over the 32-bit argument range.
  function automatic longint isqrt_ref(input longint v);
    longint lo;
    longint hi;
    longint mid;
    lo = 0;
    hi = 65536;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int NA = (gi == 1) ? 5 : 3;
    localparam int NI = 2;
    localparam int RW = (gi == 2) ? 4 : 32;
    localparam int R  = (NA + NI - 1) / NI;
    localparam int YW = NI * HW;

    logic             rst;
    logic             arg_vld;
    logic             arg_rdy;
    logic [NA*W-1:0]  args;
    logic             res_vld;
    logic [RW-1:0]    res;
    logic [NI-1:0]    x_vld;
    logic [NI*W-1:0]  x;
    logic [NI-1:0]    y_vld;
    logic [YW-1:0]    y;

    exp_t          exp_q[$];
    launch_t       launch_q[$];
    pend_t         pend_q[$];
    int            lat [NI];
    logic [RW-1:0] hold;

    formula_sum_isqrt_n_fsm #(
      .N_ARGS (NA),
      .N_ISQRT(NI),
      .W      (W),
      .RES_W  (RW)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .arg_vld    (arg_vld),
      .arg_rdy    (arg_rdy),
      .args       (args),
      .res_vld    (res_vld),
      .res        (res),
      .isqrt_x_vld(x_vld),
      .isqrt_x    (x),
      .isqrt_y_vld(y_vld),
      .isqrt_y    (y)
    );

    function automatic longint model_res(input logic [NA*W-1:0] a);
      longint s;
      s = 0;
      for (int i = 0; i < NA; i++) s += isqrt_ref(longint'(a[i*W +: W]));
      return s % (longint'(1) << RW);
    endfunction

    // Each round costs one issue cycle plus the slowest used lane.
    function automatic int model_lat();
      int t;
      int mx;
      t = 1;
      for (int r = 0; r < R; r++) begin
        mx = 0;
        for (int j = 0; j < NI; j++) begin
          if (r * NI + j < NA && lat[j] > mx) mx = lat[j];
        end
        t += mx + 1;
      end
      return t;
    endfunction

    function automatic logic [NA*W-1:0] rand_args();
      logic [NA*W-1:0] a;
      longint r;
      for (int i = 0; i < NA; i++) begin
        r = longint'($urandom_range(0, 65535));
        case ($urandom_range(0, 4))
          0:       a[i*W +: W] = '0;
          1:       a[i*W +: W] = '1;
          2:       a[i*W +: W] = W'(r * r);
          3:       a[i*W +: W] = W'(r * r + 2 * r);
          default: a[i*W +: W] = $urandom;
        endcase
      end
      return a;
    endfunction

    task automatic expect_req(input logic [NA*W-1:0] a, input longint cres, input int clat);
      exp_t    e;
      launch_t l;
      e.res   = (cres < 0) ? model_res(a) : cres;
      e.t_acc = cyc + 1;
      e.lat   = (clat < 0) ? model_lat() : clat;
      exp_q.push_back(e);
      for (int k = 0; k < NA; k++) begin
        l.lane = k % NI;
        l.val  = longint'(a[k*W +: W]);
        launch_q.push_back(l);
      end
    endtask

    task automatic send(input logic [NA*W-1:0] a, input longint cres, input int clat);
      int guard;
      guard   = 0;
      args    = a;
      arg_vld = 1'b1;
      while (arg_rdy !== 1'b1 && guard < 3000) begin
        @(negedge clk);
        guard++;
      end
      chk(gi, "accept_timeout", arg_rdy, 1);
      if (arg_rdy === 1'b1) expect_req(a, cres, clat);
      @(negedge clk);
      arg_vld = 1'b0;
      args    = rand_args();
    endtask

    task automatic wait_idle();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 3000) begin
        @(negedge clk);
        guard++;
      end
      chk(gi, "result_timeout", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
    endtask

    task automatic do_reset();
      rst     = 1'b1;
      arg_vld = 1'b0;
      exp_q.delete();
      launch_q.delete();
      hold = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
    endtask

    task automatic chk_reset_state();
      chk(gi, "rst_arg_rdy", arg_rdy, 1);
      chk(gi, "rst_res_vld", res_vld, 0);
      chk(gi, "rst_res", res, 0);
      chk(gi, "rst_x_vld", x_vld, 0);
    endtask

    // Behavioural isqrt lanes plus launch checking against the expected operands.
    always @(negedge clk) begin
      pend_t p;
      int    hit;
      for (int j = 0; j < NI; j++) begin
        if (x_vld[j] === 1'b1) begin
          p.lane = j;
          p.due  = cyc + 1 + lat[j];
          p.val  = HW'(isqrt_ref(longint'(x[j*W +: W])));
          pend_q.push_back(p);
          hit = -1;
          for (int k = 0; k < launch_q.size(); k++) begin
            if (hit < 0 && launch_q[k].lane == j) hit = k;
          end
          chk(gi, "lane_launch_expected", hit >= 0, 1);
          if (hit >= 0) begin
            chk(gi, "lane_operand", x[j*W +: W], launch_q[hit].val);
            launch_q.delete(hit);
          end
        end
      end
      y_vld = '0;
      y     = YW'($urandom);
      for (int k = pend_q.size() - 1; k >= 0; k--) begin
        if (pend_q[k].due == cyc + 1) begin
          y_vld[pend_q[k].lane]         = 1'b1;
          y[pend_q[k].lane*HW +: HW]    = pend_q[k].val;
          pend_q.delete(k);
        end
      end
    end

    always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b0) begin
        if (res_vld === 1'b1) begin
          chk(gi, "res_vld_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(gi, "res", res, e.res);
            chk(gi, "latency", cyc + 1 - e.t_acc, e.lat);
            hold = RW'(e.res);
          end
        end else begin
          chk(gi, "res_hold", res, hold);
        end
      end
    end

    initial begin
      logic [NA*W-1:0] a;
      int guard;
      rst     = 1'b1;
      arg_vld = 1'b0;
      args    = '0;
      hold    = '0;
      lat[0]  = 4;
      lat[1]  = 4;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_reset_state();

      // Directed vector for this configuration, with known sum and latency.
      for (int i = 0; i < NA; i++) begin
        a[i*W +: W] = (gi == 0) ? W'((4 - i) * (4 - i)) :
                      (gi == 1) ? W'((i + 1) * (i + 1)) : 32'hFFFE0001;
      end
      send(a, (gi == 0) ? 9 : (gi == 1) ? 15 : 13, (gi == 1) ? 16 : 11);
      wait_idle();

      // Lanes with unequal latency.
      lat[0] = 2;
      lat[1] = 7;
      a = rand_args();
      if (gi == 0) begin
        for (int i = 0; i < NA; i++) a[i*W +: W] = (i == 0) ? 32'd100 : (i == 1) ? 32'd49 : 32'd0;
      end
      send(a, (gi == 0) ? 17 : -1, -1);
      wait_idle();

      // arg_vld held high with fresh operands every cycle.
      lat[0] = 3;
      lat[1] = 3;
      for (int n = 0; n < 60; n++) begin
        args    = rand_args();
        arg_vld = 1'b1;
        if (arg_rdy === 1'b1) expect_req(args, -1, -1);
        @(negedge clk);
      end
      arg_vld = 1'b0;
      wait_idle();

      // Reset while waiting on lanes; their late results must be ignored.
      lat[0] = 6;
      lat[1] = 6;
      send(rand_args(), -1, -1);
      repeat (3) @(negedge clk);
      do_reset();
      chk_reset_state();
      guard = 0;
      while (pend_q.size() != 0 && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      chk(gi, "stale_drain_timeout", pend_q.size(), 0);
      @(negedge clk);
      chk(gi, "post_rst_res", res, 0);
      for (int i = 0; i < NA; i++) a[i*W +: W] = 32'd4;
      send(a, (gi == 0) ? 6 : -1, -1);
      wait_idle();

      // Randomised operands and lane latencies.
      for (int n = 0; n < 20; n++) begin
        lat[0] = $urandom_range(1, 5);
        lat[1] = $urandom_range(1, 5);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(rand_args(), -1, -1);
        wait_idle();
      end

      chk(gi, "launch_q_drained", launch_q.size(), 0);
      n_fin++;
    end
  end

  initial begin
    while (n_fin < NCFG && cyc < 80000) @(negedge clk);
    if (n_fin < NCFG) begin
      n_checks++;
      n_fail++;
      $display("FAIL global_timeout: got %0d finished configs, expected %0d", n_fin, NCFG);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
